fsm_ab_driver: RTL and testbench

- Drives the `a`/`b` input pair of the two-segment Moore/Mealy example FSM (`fsm_eg_2_seg`) from a queue of timed commands.
- It is the source end of the a/b interface that the FSM consumes.
- It also listens to the FSM's Mealy output `y0` and counts asserted cycles, so a bring-up design can run and self-check the FSM without a testbench.
- Sits beside the FSM in the top level: command port on one side, `a`/`b` out to the FSM, `y0` back in.

---
 rtl/fsm_ab_driver.sv | 216 +++++++++++++++++++++
 tb/tb_fsm_ab_driver.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ab_driver.sv
// -----------------------------------------------------------------------------
// fsm_ab_driver
//
// Purpose
//   Source end of the a/b interface consumed by the two-segment Moore/Mealy
//   example FSM. Timed commands {a, b, len} are queued in a small FIFO and
//   played out on the registered a/b outputs, each held for max(len,1)
//   cycles, back to back with no idle gap while the queue has entries. The
//   FSM's Mealy output y0 is fed back and the cycles in which it is high
//   while driving are counted (saturating), so a bring-up top level can run
//   and self-check the FSM on its own.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO can accept a command (= not full)
//   cmd_a      in   value to drive on a
//   cmd_b      in   value to drive on b
//   cmd_len    in   [LEN_W] cycles to hold a/b (0 behaves as 1)
//   a, b       out  registered drive to the FSM inputs
//   y0         in   Mealy output returned from the FSM
//   clr_count  in   synchronous clear of y0_count (wins over increment)
//   busy       out  high while in DRIVE
//   done       out  one-cycle pulse in the first IDLE cycle after the last
//                   queued command finishes
//   y0_count   out  [CNT_W] saturating count of DRIVE cycles with y0=1
//
// Command handshake
//   A command transfers on a rising clk edge where cmd_valid && cmd_ready.
//   cmd_ready depends only on registered FIFO state (never on cmd_valid),
//   it is low whenever the FIFO is full -- even if an entry is popped at the
//   same edge -- and the offering side may hold or change cmd_valid and the
//   payload freely while cmd_ready is low; nothing is taken until it is high.
// -----------------------------------------------------------------------------
module fsm_ab_driver #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_a,
    input  logic             cmd_b,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             a,
    output logic             b,
    input  logic             y0,
    input  logic             clr_count,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] y0_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO: circular buffer, pointers one bit wider than the
    // index so that full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic             mem_a   [DEPTH];
    logic             mem_b   [DEPTH];
    logic [LEN_W-1:0] mem_len [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    logic             head_a;
    logic             head_b;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W-1:0] load_len;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head_a   = mem_a[rd_ptr[AW-1:0]];
    assign head_b   = mem_b[rd_ptr[AW-1:0]];
    assign head_len = mem_len[rd_ptr[AW-1:0]];

    // A zero-length command still occupies one cycle on the wires.
    assign load_len = (head_len == '0) ? LEN_W'(1) : head_len;

    // Storage carries no reset: an entry is only ever read after it has
    // been written, and reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]]   <= cmd_a;
            mem_b[wr_ptr[AW-1:0]]   <= cmd_b;
            mem_len[wr_ptr[AW-1:0]] <= cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drive state machine
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] hold;
    logic [LEN_W-1:0] hold_next;
    logic             a_next;
    logic             b_next;
    logic             done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
            a     <= a_next;
            b     <= b_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold;
        a_next     = a;
        b_next     = b;
        done_next  = 1'b0;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                a_next = 1'b0;
                b_next = 1'b0;
                if (!empty) begin
                    pop        = 1'b1;
                    a_next     = head_a;
                    b_next     = head_b;
                    hold_next  = load_len;
                    state_next = DRIVE;
                end
            end

            DRIVE: begin
                if (hold == LEN_W'(1)) begin
                    // Last cycle of this command. The emptiness seen here
                    // comes from registered pointers, so a command pushed at
                    // this same edge is picked up from IDLE one cycle later.
                    if (!empty) begin
                        pop       = 1'b1;
                        a_next    = head_a;
                        b_next    = head_b;
                        hold_next = load_len;
                    end else begin
                        a_next     = 1'b0;
                        b_next     = 1'b0;
                        hold_next  = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    hold_next = hold - LEN_W'(1);
                end
            end

            default: begin
                a_next     = 1'b0;
                b_next     = 1'b0;
                hold_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == DRIVE);

    // ------------------------------------------------------------------
    // y0 event counter: only DRIVE cycles count, clear beats increment,
    // and the count sticks at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            y0_count <= '0;
        end else if (clr_count) begin
            y0_count <= '0;
        end else if ((state == DRIVE) && y0 && (y0_count != '1)) begin
            y0_count <= y0_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fsm_ab_driver.sv
// -----------------------------------------------------------------------------
// tb_fsm_ab_driver
//
// Directed bench for fsm_ab_driver. Inputs are changed and outputs sampled on
// the falling edge; each table row describes the inputs applied before a
// rising edge and the outputs expected after it. The observable output
// vector is {a, b, cmd_ready, busy, done}. A small model of the two-segment
// example FSM closes the y0 loop for the loopback sequence.
// -----------------------------------------------------------------------------
module tb_fsm_ab_driver;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_a;
  logic             cmd_b;
  logic [LEN_W-1:0] cmd_len;
  logic             a;
  logic             b;
  logic             y0;
  logic             clr_count;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] y0_count;

  fsm_ab_driver #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_len   (cmd_len),
    .a         (a),
    .b         (b),
    .y0        (y0),
    .clr_count (clr_count),
    .busy      (busy),
    .done      (done),
    .y0_count  (y0_count)
  );

  // ---------------- example FSM model (y0 source in loopback) ----------------
  typedef enum logic [1:0] {M_S0, M_S1, M_S2} m_state_t;
  m_state_t m_state;
  logic     model_y0;
  logic     loop_en;
  logic     y0_force;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_state <= M_S0;
    end else begin
      case (m_state)
        M_S0: if (a) m_state <= b ? M_S2 : M_S1;
        M_S1: if (a) m_state <= M_S0;
        default: m_state <= M_S0;
      endcase
    end
  end

  assign model_y0 = (m_state == M_S0) && a && b;
  assign y0 = loop_en ? model_y0 : y0_force;

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    clr_count = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  // Offer one command and hold it until it is taken (bounded wait).
  task automatic push_cmd(input logic ca, input logic cb, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end else begin
      cmd_valid = 1'b1;
      cmd_a     = ca;
      cmd_b     = cb;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic             vld;
    logic             ca;
    logic             cb;
    logic [LEN_W-1:0] len;
    logic             y0v;
    logic             clr;
    logic [4:0]       exp;      // {a, b, cmd_ready, busy, done}
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl[NVEC];

  logic [1:0] offer_ab[1:5];
  logic [1:0] cur;
  logic       e_busy;
  logic       e_ready;
  logic       e_done;
  logic [1:0] e_ab;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 1'b0;
    cmd_b     = 1'b0;
    cmd_len   = '0;
    clr_count = 1'b0;
    loop_en   = 1'b0;
    y0_force  = 1'b0;
    cur       = 2'b00;

    //             rst   vld   ca    cb    len    y0    clr   exp       cnt
    // reset, then idle with y0 high (ignored while IDLE)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00100, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00100, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b00100, 8'd0};
    // single command (1,0,len=3) pushed at edge k
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 5'b00100, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b10110, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b10110, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b10110, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b00101, 8'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'b00100, 8'd2};
    // back to back (0,1,2), (1,1,1), (1,0,0); clr_count on the first push
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 5'b00100, 8'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 5'b01110, 8'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'b01110, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b11110, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b10110, 8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00101, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'b00100, 8'd0};

    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      reset     = tbl[i].rst;
      cmd_valid = tbl[i].vld;
      cmd_a     = tbl[i].ca;
      cmd_b     = tbl[i].cb;
      cmd_len   = tbl[i].len;
      y0_force  = tbl[i].y0v;
      clr_count = tbl[i].clr;
      tick();
      check($sformatf("tbl[%0d].out", i), 16'({a, b, cmd_ready, busy, done}), 16'(tbl[i].exp));
      check($sformatf("tbl[%0d].y0_count", i), 16'(y0_count), 16'(tbl[i].exp_cnt));
    end
    cmd_valid = 1'b0;
    y0_force  = 1'b0;
    clr_count = 1'b0;

    // ---------------- full FIFO, len=15 each ----------------
    do_reset();
    exp_q = {2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    offer_ab[1] = 2'b01;
    offer_ab[2] = 2'b11;
    offer_ab[3] = 2'b10;
    offer_ab[4] = 2'b01;
    offer_ab[5] = 2'b11;   // offered while full, must never be driven
    cmd_valid = 1'b1;
    cmd_a     = 1'b1;
    cmd_b     = 1'b0;
    cmd_len   = 4'd15;
    tick();                 // edge k: first command pushed
    for (int j = 0; j <= 76; j++) begin
      if (j >= 1 && j <= 75 && ((j - 1) % 15) == 0) cur = exp_q.pop_front();
      e_busy  = (j >= 1 && j <= 75);
      e_ab    = e_busy ? cur : 2'b00;
      e_ready = !(j >= 4 && j <= 15);
      e_done  = (j == 76);
      check($sformatf("full_fifo j=%0d", j), 16'({a, b, cmd_ready, busy, done}),
            16'({e_ab, e_ready, e_busy, e_done}));
      if (j + 1 <= 4) begin
        cmd_valid = 1'b1;
        {cmd_a, cmd_b} = offer_ab[j + 1];
      end else if (j + 1 <= 7) begin
        cmd_valid = 1'b1;
        {cmd_a, cmd_b} = offer_ab[5];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    check("full_fifo.after", 16'({a, b, cmd_ready, busy, done}), 16'(5'b00100));

    // ---------------- y0 counting, saturation and clear ----------------
    do_reset();
    y0_force = 1'b1;
    push_cmd(1'b1, 1'b0, 4'd5);
    wait_done(40, "cnt5.done");
    tick();
    tick();
    check("cnt_len5", 16'(y0_count), 16'd5);
    for (int i = 0; i < 20; i++) push_cmd(1'b0, 1'b1, 4'd15);
    wait_done(400, "sat.done");
    check("cnt_saturate", 16'(y0_count), 16'd255);
    push_cmd(1'b1, 1'b1, 4'd4);
    tick();
    check("clr.busy", 16'(busy), 16'd1);
    clr_count = 1'b1;
    tick();
    check("clr_with_y0", 16'(y0_count), 16'd0);
    clr_count = 1'b0;
    y0_force  = 1'b0;
    tick();
    check("clr_hold", 16'(y0_count), 16'd0);
    wait_done(40, "clr.done");
    y0_force = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_y0_ignored", 16'(y0_count), 16'd0);
    y0_force = 1'b0;

    // ---------------- loopback through the FSM model ----------------
    do_reset();
    loop_en = 1'b1;
    push_cmd(1'b1, 1'b1, 4'd1);
    push_cmd(1'b0, 1'b0, 4'd1);
    push_cmd(1'b1, 1'b1, 4'd1);
    wait_done(40, "loop.done");
    tick();
    check("loopback_count", 16'(y0_count), 16'd2);
    loop_en = 1'b0;

    // ---------------- reset mid-command ----------------
    do_reset();
    cmd_valid = 1'b1;
    {cmd_a, cmd_b} = 2'b11;
    cmd_len   = 4'd8;
    tick();                         // edge k: push c0
    {cmd_a, cmd_b} = 2'b10;
    cmd_len   = 4'd1;
    tick();                         // edge k+1: c0 first DRIVE cycle, push c1
    {cmd_a, cmd_b} = 2'b01;
    tick();                         // edge k+2: c0 second cycle, push c2
    check("midrst.pre", 16'({a, b, cmd_ready, busy, done}), 16'(5'b11110));
    cmd_valid = 1'b0;
    reset     = 1'b1;
    tick();
    check("midrst.at_reset", 16'({a, b, cmd_ready, busy, done}), 16'(5'b00100));
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("midrst.after[%0d]", i), 16'({a, b, cmd_ready, busy, done}), 16'(5'b00100));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
